// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Instruction-fetch sequencer with in-order buffer, redirect, fault.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_SIZE  = 6,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [31:0]                        imem_addr,
  input  logic [31:0]                        imem_instr,
  input  logic                               en,
  input  logic                               redirect_valid,
  input  logic [31:0]                        redirect_pc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [31:0]                        out_pc,
  output logic [31:0]                        out_instr,
  output logic                               fault,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FAULT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      fpc_q, fpc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_buf_q [BUF_DEPTH];
  logic [31:0]      pc_buf_d [BUF_DEPTH];
  logic [31:0]      instr_buf_q [BUF_DEPTH];
  logic [31:0]      instr_buf_d [BUF_DEPTH];
  logic [31:0]      out_pc_q, out_pc_d, out_instr_q, out_instr_d;

  logic fpc_legal, fetch_ok, pop, push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fpc_legal = (fpc_q[1:0] == 2'b00) && (fpc_q[31:2] < 30'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = S_RUN;
    else if ((state_q == S_RUN) && en && !fpc_legal)
      state_d = S_FAULT;
  end

  always_comb begin
    fault    = (state_q == S_FAULT);
    fetch_ok = (state_q == S_RUN) && en && !redirect_valid && fpc_legal;
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = fetch_ok && ((count_q < CNT_W'(BUF_DEPTH)) || pop);

  always_comb begin
    fpc_d       = fpc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_buf_d    = pc_buf_q;
    instr_buf_d = instr_buf_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (redirect_valid) begin
      // Flush: drop everything, same-cycle pop and push are discarded.
      fpc_d       = redirect_pc;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_pc_d    = '0;
      out_instr_d = '0;
    end else begin
      if (push) begin
        pc_buf_d[wr_ptr_q]    = fpc_q;
        instr_buf_d[wr_ptr_q] = imem_instr;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
        fpc_d                 = fpc_q + 32'd4;
      end
      if (pop)
        rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // Head registers follow the new head; they hold when the buffer empties.
      if (count_d != '0) begin
        out_pc_d    = pc_buf_d[rd_ptr_d];
        out_instr_d = instr_buf_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_buf_q[i]    <= '0;
        instr_buf_q[i] <= '0;
      end
    end else begin
      fpc_q       <= fpc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      pc_buf_q    <= pc_buf_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  assign imem_addr = fpc_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign buf_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Directed self-checking bench for fetch_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [1:0]  buf_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .MEM_SIZE(6), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .en(en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fault(fault), .buf_count(buf_count)
  );

  function automatic logic [31:0] word_at(input int idx);
    case (idx)
      0:       return 32'h0000_0013;
      1:       return 32'h0010_0093;
      2:       return 32'h0020_0113;
      3:       return 32'h0030_0193;
      4:       return 32'h0040_0213;
      5:       return 32'h0050_0293;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Asynchronous-read memory with 6 words.
  assign imem_instr = (imem_addr[31:2] < 30'd6) ? word_at(int'(imem_addr[4:2])) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    tick();
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);

    // 1: streaming run into the end of memory
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_pc", out_pc, 32'(i * 4));
      check("t1_instr", out_instr, word_at(i));
    end
    check("t1_addr18", imem_addr, 32'h18);
    check("t1_fault_pre", 32'(fault), 32'd0);
    tick();
    check("t1_fault", 32'(fault), 32'd1);
    check("t1_empty", 32'(out_valid), 32'd0);
    check("t1_hold_pc", out_pc, 32'h14);
    tick();
    check("t1_fault_sticky", 32'(fault), 32'd1);
    check("t1_addr_hold", imem_addr, 32'h18);

    // 2: backpressure then drain in order
    do_reset();
    out_ready = 1'b0; en = 1'b1;
    tick();
    check("t2_cnt1", 32'(buf_count), 32'd1);
    tick();
    check("t2_cnt2", 32'(buf_count), 32'd2);
    check("t2_addr", imem_addr, 32'h8);
    tick();
    check("t2_full_addr", imem_addr, 32'h8);
    check("t2_head0", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check("t2_pc4", out_pc, 32'h4);
    check("t2_cnt_full", 32'(buf_count), 32'd2);
    tick();
    check("t2_pc8", out_pc, 32'h8);
    check("t2_instr8", out_instr, word_at(2));
    tick();
    check("t2_pcC", out_pc, 32'hC);

    // 3: redirect while full with a same-cycle pop
    do_reset();
    out_ready = 1'b0; en = 1'b1;
    tick(); tick();
    check("t3_full", 32'(buf_count), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h10; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t3_cnt0", 32'(buf_count), 32'd0);
    check("t3_valid0", 32'(out_valid), 32'd0);
    check("t3_pc_zero", out_pc, 32'h0);
    check("t3_addr", imem_addr, 32'h10);
    tick();
    check("t3_pc10", out_pc, 32'h10);
    check("t3_instr10", out_instr, word_at(4));
    tick();
    check("t3_pc14", out_pc, 32'h14);
    tick();
    check("t3_fault", 32'(fault), 32'd1);

    // 4: redirect to a misaligned address, then recover
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    check("t4_fault_clr", 32'(fault), 32'd0);
    check("t4_addr6", imem_addr, 32'h6);
    tick();
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_nopush", 32'(buf_count), 32'd0);
    tick();
    check("t4_addr_hold", imem_addr, 32'h6);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("t4_fault0", 32'(fault), 32'd0);
    tick();
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_pc0", out_pc, 32'h0);

    // 5: reset mid-stream
    do_reset();
    out_ready = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_pre_cnt", 32'(buf_count), 32'd2);
    check("t5_pre_addr", imem_addr, 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_cnt", 32'(buf_count), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_fault", 32'(fault), 32'd0);
    check("t5_addr", imem_addr, 32'h0);

    // 6: en=0 drains without fetching, then resumes
    out_ready = 1'b0; en = 1'b1;
    tick(); tick();
    en = 1'b0; out_ready = 1'b1;
    tick();
    check("t6_cnt1", 32'(buf_count), 32'd1);
    check("t6_pc4", out_pc, 32'h4);
    check("t6_addr_a", imem_addr, 32'h8);
    tick();
    check("t6_cnt0", 32'(buf_count), 32'd0);
    check("t6_addr_b", imem_addr, 32'h8);
    en = 1'b1;
    tick();
    check("t6_resume_pc", out_pc, 32'h8);
    check("t6_resume_valid", 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the processor's asynchronous-read instruction memory.
- Owns the fetch PC and drives the memory's byte address.
- Captures returned words into a small in-order buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Handles branch/jump redirects (flush plus PC reload) and flags out-of-range or misaligned fetches with a sticky fault.

Parameters:
- reset_pc, 32'h0, fetch PC value loaded on reset.
- mem_size, 6, number of instruction words in the attached memory; valid word indices are 0..mem_size-1.
- buf_depth, 2, instruction buffer depth in entries (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals fetch PC (fpc) combinationally.
- imem_instr  input  32  word returned by memory for imem_addr, same cycle.
- en  input  1  fetch enable; 0 stops pushes, drain continues.
- redirect_valid  input  1  load redirect_pc and flush the buffer.
- redirect_pc  input  32  new fetch byte address.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- fault  output  1  sticky fetch fault.
- buf_count  output  $clog2(buf_depth+1)  occupied entries.

Behaviour:
- Reset (rst=1 at an edge):
  - fpc=reset_pc, buffer emptied, storage zeroed.
  - out_valid=0, out_pc=0, out_instr=0, fault=0, buf_count=0, state=RUN.
  - rst overrides every other input in the same cycle, including mid-stream.
- States: RUN and FAULT.
- Fetch legality: fpc is legal iff fpc[1:0]==0 and fpc[31:2] < mem_size (unsigned compare).
- Pop: occurs when out_valid && out_ready; the head advances at the edge.
- Push (RUN only): occurs when en=1, redirect_valid=0, fpc is legal, and (buf_count<buf_depth or a pop occurs this cycle).
  - Writes {fpc, imem_instr} at the tail; fpc <= fpc+4 (32-bit wrap).
  - Push and pop may occur together when full; count is unchanged.
- Fault entry: in RUN with en=1, redirect_valid=0 and fpc illegal:
  - No push; next cycle state=FAULT, fault=1; fpc holds.
  - Buffered entries still drain normally.
- In FAULT: no pushes; fault stays 1 until a redirect or rst.
- Redirect (redirect_valid=1, any state):
  - Next cycle the buffer is empty (buf_count=0, out_valid=0), fpc=redirect_pc, state=RUN, fault=0.
  - Any same-cycle pop has no further effect; no push that cycle.
  - A redirect to an illegal address enters FAULT one cycle later, via the legality check.
- Latency: memory-to-output is one cycle. A word fetched at edge N appears on out_* from cycle N+1 and stays stable until popped or flushed.
- out_pc/out_instr: show the head entry when out_valid=1; hold last head contents (or 0 after reset/flush) when empty. Never consumed when out_valid=0.
- Buffer is a circular FIFO; read/write pointers wrap modulo buf_depth; order strictly preserved.
- en=0: no pushes and fpc holds; pops continue.

Test Plan:
1. Memory holds 6 words, en=1, out_ready=1 after reset -> out_pc 0x0,0x4,...,0x14 on consecutive cycles from cycle 1, matching the memory words; fpc reaches 0x18, fault=1 on the following cycle; out_valid=0 after 0x14 is consumed.
2. out_ready=0 from reset -> buf_count 1 then 2; imem_addr holds 0x8; raise out_ready -> out_pc 0x0,0x4,0x8 in order with no duplicates or gaps.
3. Buffer full (0x0,0x4), redirect_valid=1 with redirect_pc=0x10 and out_ready=1 in the same cycle -> next cycle buf_count=0, out_valid=0; then out_pc 0x10, 0x14 follow.
4. redirect_pc=0x6 -> one cycle later fault=1, no pushes; then redirect_pc=0x0 -> fault=0 and out_pc=0x0 the following cycle.
5. rst=1 pulsed while buffer holds 2 entries and fpc=0xC -> next cycle buf_count=0, out_valid=0, fault=0, imem_addr=reset_pc.
6. en=0 with buffer full and out_ready=1 -> buffer drains in 2 cycles, imem_addr constant; en=1 resumes at the held fpc.
